// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises LSB loads/stores and instruction fetches onto a byte-wide RAM/IO port
module mem_ctrl #(
    parameter int IO_SEL_HI   = 17,
    parameter int FETCH_BYTES = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        go_work,
    input  logic        l_or_s,
    input  logic [2:0]  width,
    input  logic [31:0] address,
    input  logic [31:0] value_store,
    output logic        received,
    output logic        has_result,
    output logic [31:0] value_load,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_inst,
    input  logic        clear_in,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {IDLE, LOAD, STORE, FETCH} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d, cnt_n;
    logic [2:0]  wid_q, wid_d;
    logic [31:0] base_q, base_d;
    logic [31:0] sdata_q, sdata_d;
    logic [31:0] asm_q, asm_d;
    logic        received_q, received_d;
    logic        has_result_q, has_result_d;
    logic        if_ready_q, if_ready_d;
    logic [31:0] value_load_q, value_load_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic        frz_q, frz_d;
    logic [7:0]  din_sv_q, din_sv_d;
    logic [7:0]  din;
    logic        io_blk;

    // The RAM keeps reading while frozen, so after a freeze mem_din reflects the
    // held address rather than the previous one; replay the byte seen when the freeze began.
    assign din    = frz_q ? din_sv_q : mem_din;
    assign io_blk = (base_q[IO_SEL_HI:IO_SEL_HI-1] == 2'b11) && io_buffer_full;
    assign cnt_n  = cnt_q + 3'd1;

    assign received   = received_q;
    assign has_result = has_result_q;
    assign value_load = value_load_q;
    assign if_ready   = if_ready_q;
    assign if_inst    = if_inst_q;
    assign mem_a      = mem_a_q;
    assign mem_dout   = mem_dout_q;
    assign mem_wr     = mem_wr_q && rdy_in && !io_blk;

    // Next-state: arbitration in IDLE, byte sequencing in LOAD/FETCH/STORE; everything holds while frozen
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wid_d        = wid_q;
        base_d       = base_q;
        sdata_d      = sdata_q;
        asm_d        = asm_q;
        received_d   = received_q;
        has_result_d = has_result_q;
        if_ready_d   = if_ready_q;
        value_load_d = value_load_q;
        if_inst_d    = if_inst_q;
        mem_a_d      = mem_a_q;
        mem_dout_d   = mem_dout_q;
        mem_wr_d     = mem_wr_q;
        frz_d        = !rdy_in;
        din_sv_d     = din;
        if (rdy_in) begin
            received_d   = 1'b0;
            has_result_d = 1'b0;
            if_ready_d   = 1'b0;
            case (state_q)
                IDLE: begin
                    if (go_work) begin
                        state_d    = l_or_s ? STORE : LOAD;
                        cnt_d      = 3'd0;
                        wid_d      = width;
                        base_d     = address;
                        sdata_d    = value_store;
                        asm_d      = 32'd0;
                        received_d = 1'b1;
                        mem_a_d    = address;
                        mem_dout_d = value_store[7:0];
                        mem_wr_d   = l_or_s;
                    end else if (if_req && !clear_in) begin
                        state_d = FETCH;
                        cnt_d   = 3'd0;
                        wid_d   = 3'(FETCH_BYTES);
                        base_d  = if_addr;
                        asm_d   = 32'd0;
                        mem_a_d = if_addr;
                    end
                end
                LOAD, FETCH: begin
                    if (state_q == FETCH && clear_in) begin
                        state_d = IDLE;
                    end else begin
                        // byte k arrives one cycle after its address, i.e. while cnt == k+1
                        for (int i = 0; i < 4; i++)
                            if (cnt_q == 3'(i + 1)) asm_d[8*i +: 8] = din;
                        if (cnt_q == wid_q) begin
                            state_d = IDLE;
                            if (state_q == LOAD) begin
                                has_result_d = 1'b1;
                                value_load_d = asm_d;
                            end else begin
                                if_ready_d = 1'b1;
                                if_inst_d  = asm_d;
                            end
                        end else begin
                            cnt_d = cnt_n;
                            // hold the last address in the final sampling cycle to avoid a stray IO read
                            if (cnt_n < wid_q) mem_a_d = base_q + 32'(cnt_n);
                        end
                    end
                end
                STORE: begin
                    if (!io_blk) begin
                        if (cnt_n == wid_q) begin
                            state_d  = IDLE;
                            mem_wr_d = 1'b0;
                        end else begin
                            cnt_d      = cnt_n;
                            mem_a_d    = base_q + 32'(cnt_n);
                            mem_dout_d = sdata_q[{cnt_n[1:0], 3'b000} +: 8];
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and registered outputs; asynchronous active-low reset abandons any access
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            wid_q        <= 3'd0;
            base_q       <= 32'd0;
            sdata_q      <= 32'd0;
            asm_q        <= 32'd0;
            received_q   <= 1'b0;
            has_result_q <= 1'b0;
            if_ready_q   <= 1'b0;
            value_load_q <= 32'd0;
            if_inst_q    <= 32'd0;
            mem_a_q      <= 32'd0;
            mem_dout_q   <= 8'd0;
            mem_wr_q     <= 1'b0;
            frz_q        <= 1'b0;
            din_sv_q     <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wid_q        <= wid_d;
            base_q       <= base_d;
            sdata_q      <= sdata_d;
            asm_q        <= asm_d;
            received_q   <= received_d;
            has_result_q <= has_result_d;
            if_ready_q   <= if_ready_d;
            value_load_q <= value_load_d;
            if_inst_q    <= if_inst_d;
            mem_a_q      <= mem_a_d;
            mem_dout_q   <= mem_dout_d;
            mem_wr_q     <= mem_wr_d;
            frz_q        <= frz_d;
            din_sv_q     <= din_sv_d;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench for mem_ctrl with a latency/schedule model and a byte RAM
module tb_mem_ctrl;

    localparam int N = 512;
    localparam int NOF = 100000;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        go_work = 1'b0;
    logic        l_or_s = 1'b0;
    logic [2:0]  width = 3'd0;
    logic [31:0] address = 32'd0;
    logic [31:0] value_store = 32'd0;
    logic        received, has_result, if_ready, mem_wr;
    logic [31:0] value_load, if_inst, mem_a;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        clear_in = 1'b0;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  mem_dout;
    logic        io_buffer_full = 1'b0;

    mem_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .go_work(go_work), .l_or_s(l_or_s), .width(width), .address(address),
        .value_store(value_store), .received(received), .has_result(has_result),
        .value_load(value_load), .if_req(if_req), .if_addr(if_addr),
        .if_ready(if_ready), .if_inst(if_inst), .clear_in(clear_in),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    // RAM contents (read-only image) and a separate log of written bytes
    logic [7:0] ram  [4096];
    logic [7:0] wmem [4096];
    int n_wr = 0;
    always @(posedge clk_in) begin
        mem_din <= ram[mem_a[11:0]];
        if (mem_wr) begin
            wmem[mem_a[11:0]] <= mem_dout;
            n_wr <= n_wr + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Expected per-cycle observations
    logic        exp_recv [N];
    logic        exp_res  [N];
    logic        exp_ifr  [N];
    logic        exp_wr   [N];
    logic        exp_achk [N];
    logic [31:0] exp_val  [N];
    logic [31:0] exp_inst [N];
    logic [31:0] exp_a    [N];
    logic [31:0] exp_d    [N];

    int n_chk = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, a, e);
        end
    endtask

    // Logical cycle c lands later by n if a stall of n cycles began at or before it
    function automatic int act(input int c, input int fs, input int n);
        return (c >= fs) ? c + n : c;
    endfunction

    // Read transaction: address k in cycle k, result w+1 cycles after accept
    task automatic sched_rd(input int c0, input bit fetch, input logic [31:0] base,
                            input int w, input int fs, input int n);
        logic [31:0] v;
        logic [31:0] a;
        int c;
        v = 32'd0;
        for (int k = 0; k < w; k++) begin
            a = base + 32'(k);
            v = v | (32'(ram[a[11:0]]) << (8 * k));
            c = act(c0 + k, fs, n);
            exp_achk[c] = 1'b1;
            exp_a[c] = a;
        end
        c = act(c0 + w + 1, fs, n);
        if (fetch) begin
            exp_ifr[c] = 1'b1;
            exp_inst[c] = v;
        end else begin
            exp_recv[c0] = 1'b1;
            exp_res[c] = 1'b1;
            exp_val[c] = v;
        end
    endtask

    // Write transaction: one byte per cycle starting at the accept cycle
    task automatic sched_wr(input int c0, input logic [31:0] base, input int w,
                            input logic [31:0] d, input int fs, input int n);
        int c;
        exp_recv[c0] = 1'b1;
        for (int k = 0; k < w; k++) begin
            c = act(c0 + k, fs, n);
            exp_wr[c] = 1'b1;
            exp_a[c] = base + 32'(k);
            exp_d[c] = (d >> (8 * k)) & 32'hFF;
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic req(input bit s, input logic [2:0] w, input logic [31:0] a, input logic [31:0] d);
        go_work = 1'b1;
        l_or_s = s;
        width = w;
        address = a;
        value_store = d;
    endtask

    // Per-cycle comparison against the schedule
    always @(negedge clk_in) begin
        if (chk_en && cyc < N) begin
            chk("received", 32'(received), 32'(exp_recv[cyc]));
            chk("has_result", 32'(has_result), 32'(exp_res[cyc]));
            chk("if_ready", 32'(if_ready), 32'(exp_ifr[cyc]));
            chk("mem_wr", 32'(mem_wr), 32'(exp_wr[cyc]));
            if (exp_res[cyc]) chk("value_load", value_load, exp_val[cyc]);
            if (exp_ifr[cyc]) chk("if_inst", if_inst, exp_inst[cyc]);
            if (exp_wr[cyc]) begin
                chk("wr_addr", mem_a, exp_a[cyc]);
                chk("wr_data", 32'(mem_dout), exp_d[cyc]);
            end
            if (exp_achk[cyc]) chk("mem_a", mem_a, exp_a[cyc]);
        end
    end

    initial begin
        int c0;
        for (int i = 0; i < 4096; i++) ram[i] = 8'(i * 13 + 7);
        ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
        ram[12'h104] = 8'hA1; ram[12'h105] = 8'hB2; ram[12'h106] = 8'hC3; ram[12'h107] = 8'hD4;
        ram[12'h203] = 8'h80;
        for (int i = 0; i < N; i++) begin
            exp_recv[i] = 1'b0; exp_res[i] = 1'b0; exp_ifr[i] = 1'b0;
            exp_wr[i] = 1'b0; exp_achk[i] = 1'b0;
            exp_val[i] = 32'd0; exp_inst[i] = 32'd0; exp_a[i] = 32'd0; exp_d[i] = 32'd0;
        end

        // reset state
        #1 rst_in = 1'b0;
        tick(2);
        chk_en = 1'b1;
        chk("rst received", 32'(received), 32'd0);
        chk("rst has_result", 32'(has_result), 32'd0);
        chk("rst if_ready", 32'(if_ready), 32'd0);
        chk("rst mem_wr", 32'(mem_wr), 32'd0);
        chk("rst mem_a", mem_a, 32'd0);
        chk("rst mem_dout", 32'(mem_dout), 32'd0);
        chk("rst value_load", value_load, 32'd0);
        chk("rst if_inst", if_inst, 32'd0);
        rst_in = 1'b1;
        tick(2);

        // reset in the middle of a fetch, then a clean fetch from byte 0
        if_req = 1'b1; if_addr = 32'h100;
        c0 = cyc + 1;
        exp_achk[c0] = 1'b1;     exp_a[c0] = 32'h100;
        exp_achk[c0 + 1] = 1'b1; exp_a[c0 + 1] = 32'h101;
        tick(3);
        rst_in = 1'b0;
        #1;
        chk("midrst mem_a", mem_a, 32'd0);
        chk("midrst if_ready", 32'(if_ready), 32'd0);
        tick();
        if_req = 1'b0;
        tick();
        rst_in = 1'b1;
        tick(2);
        if_req = 1'b1;
        c0 = cyc + 1;
        sched_rd(c0, 1'b1, 32'h100, 4, NOF, 0);
        tick(6);
        chk("fetch if_inst lit", if_inst, 32'h44332211);
        if_req = 1'b0;
        tick();

        // lw at 0x100
        req(1'b0, 3'd4, 32'h100, 32'd0);
        c0 = cyc + 1;
        sched_rd(c0, 1'b0, 32'h100, 4, NOF, 0);
        tick();
        go_work = 1'b0;
        tick(5);
        chk("lw value lit", value_load, 32'h44332211);
        tick();

        // lb at 0x203: zero-filled, no sign extension
        req(1'b0, 3'd1, 32'h203, 32'd0);
        c0 = cyc + 1;
        sched_rd(c0, 1'b0, 32'h203, 1, NOF, 0);
        tick();
        go_work = 1'b0;
        tick(2);
        chk("lb value lit", value_load, 32'h00000080);
        tick();

        // sh then a back-to-back lb accepted at the edge ending cycle 2
        req(1'b1, 3'd2, 32'h40, 32'hABCD1234);
        c0 = cyc + 1;
        sched_wr(c0, 32'h40, 2, 32'hABCD1234, NOF, 0);
        tick();
        go_work = 1'b0;
        tick();
        req(1'b0, 3'd1, 32'h203, 32'd0);
        sched_rd(c0 + 3, 1'b0, 32'h203, 1, NOF, 0);
        tick(2);
        go_work = 1'b0;
        tick(2);
        chk("sh byte0 lit", 32'(wmem[12'h040]), 32'h34);
        chk("sh byte1 lit", 32'(wmem[12'h041]), 32'h12);
        tick();

        // sb to IO space with the UART buffer full for 3 cycles
        io_buffer_full = 1'b1;
        req(1'b1, 3'd1, 32'h30000, 32'h0000005A);
        c0 = cyc + 1;
        sched_wr(c0, 32'h30000, 1, 32'h5A, c0, 3);
        tick();
        go_work = 1'b0;
        tick(3);
        io_buffer_full = 1'b0;
        tick(2);
        chk("io byte lit", 32'(wmem[12'h000]), 32'h5A);
        chk("write count", n_wr, 3);

        // load and fetch requested together: load first, fetch right after
        req(1'b0, 3'd2, 32'h104, 32'd0);
        if_req = 1'b1; if_addr = 32'h200;
        c0 = cyc + 1;
        sched_rd(c0, 1'b0, 32'h104, 2, NOF, 0);
        sched_rd(c0 + 4, 1'b1, 32'h200, 4, NOF, 0);
        tick();
        go_work = 1'b0;
        tick(3);
        chk("lh value lit", value_load, 32'h0000B2A1);
        tick(6);
        if_req = 1'b0;
        tick();

        // fetch flushed in cycle 2; an lb issued next cycle proves the return to IDLE
        if_req = 1'b1; if_addr = 32'h100;
        c0 = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            exp_achk[c0 + k] = 1'b1;
            exp_a[c0 + k] = 32'h100 + 32'(k);
        end
        tick(3);
        clear_in = 1'b1; if_req = 1'b0;
        tick();
        clear_in = 1'b0;
        req(1'b0, 3'd1, 32'h203, 32'd0);
        sched_rd(c0 + 4, 1'b0, 32'h203, 1, NOF, 0);
        tick();
        go_work = 1'b0;
        tick(3);

        // if_req with clear_in in IDLE starts nothing
        if_req = 1'b1; clear_in = 1'b1;
        tick();
        if_req = 1'b0; clear_in = 1'b0;
        req(1'b0, 3'd1, 32'h203, 32'd0);
        sched_rd(cyc + 1, 1'b0, 32'h203, 1, NOF, 0);
        tick();
        go_work = 1'b0;
        tick(3);

        // rdy_in low for 2 cycles mid-lw delays the result by exactly 2
        req(1'b0, 3'd4, 32'h104, 32'd0);
        c0 = cyc + 1;
        sched_rd(c0, 1'b0, 32'h104, 4, c0 + 2, 2);
        tick();
        go_work = 1'b0;
        tick(2);
        rdy_in = 1'b0;
        chk("freeze mem_wr", 32'(mem_wr), 32'd0);
        tick(2);
        rdy_in = 1'b1;
        tick(3);
        chk("frozen lw lit", value_load, 32'hD4C3B2A1);
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
